// File: rtl/data_mem_stage.sv
// data_mem_stage
//   Memory-access stage of the 16-bit pipelined MIPS datapath. Sits between
//   execute and write-back and owns a small word-addressed data memory.
//   Loads and stores take WAIT_CYCLES extra cycles in BUSY, during which
//   stall_dm holds upstream. Pass-through results complete in one cycle.
//
// Parameters
//   ADDR_BITS   : memory address width, depth = 2**ADDR_BITS 16-bit words
//   WAIT_CYCLES : extra BUSY cycles per load/store (0..15)
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset (also clears the memory)
//   ans_ex     : ALU result / memory address (bit 0 is MSB)
//   store_data : data to store
//   mem_rd     : load request
//   mem_wr     : store request (wins over mem_rd)
//   valid_ex   : execute-stage output valid
//   stall_dm   : registered; upstream holds inputs while high
//   ans_dm     : registered result to the write block
//   valid_dm   : one-cycle pulse marking a new ans_dm
module data_mem_stage #(
    parameter int ADDR_BITS   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:15] ans_ex,
    input  logic [0:15] store_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        valid_ex,
    output logic        stall_dm,
    output logic [0:15] ans_dm,
    output logic        valid_dm
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [3:0]           wait_cnt;
    logic [0:15]          mem [DEPTH];

    logic [ADDR_BITS-1:0] addr_in;
    logic                 is_mem_op;
    logic                 accept;

    // Operation latched at the accepting edge; only consumed in BUSY
    logic [ADDR_BITS-1:0] addr_p0;
    logic [0:15]          data_p0;
    logic [0:15]          ans_p0;
    logic                 wr_p0;

    // Low-order address bits only, so addresses wrap modulo DEPTH
    assign addr_in   = ans_ex[16-ADDR_BITS:15];
    assign is_mem_op = mem_rd | mem_wr;
    // valid_ex gates the decode so unknown rd/wr on idle cycles is harmless
    assign accept    = (state == IDLE) && valid_ex && is_mem_op;

    // ---- Stage p0: capture of the accepted memory op (data path, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0 <= addr_in;
            data_p0 <= store_data;
            ans_p0  <= ans_ex;
            wr_p0   <= mem_wr;
        end
    end

    // ---- Stage p1: FSM, memory array and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            stall_dm <= 1'b0;
            valid_dm <= 1'b0;
            ans_dm   <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!valid_ex) begin
                        valid_dm <= 1'b0;
                    end else if (!is_mem_op) begin
                        ans_dm   <= ans_ex;
                        valid_dm <= 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the accepting edge is also the completion edge
                        if (mem_wr) begin
                            mem[addr_in] <= store_data;
                            ans_dm       <= ans_ex;
                        end else begin
                            ans_dm <= mem[addr_in];
                        end
                        valid_dm <= 1'b1;
                    end else begin
                        wait_cnt <= CNT_INIT;
                        stall_dm <= 1'b1;
                        valid_dm <= 1'b0;
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        valid_dm <= 1'b0;
                    end else begin
                        // Completion edge: the only place memory is read or written
                        if (wr_p0) begin
                            mem[addr_p0] <= data_p0;
                            ans_dm       <= ans_p0;
                        end else begin
                            ans_dm <= mem[addr_p0];
                        end
                        valid_dm <= 1'b1;
                        stall_dm <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    stall_dm <= 1'b0;
                    valid_dm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

    localparam int ADDR_BITS   = 4;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 2 ** ADDR_BITS;
    localparam int MAX_CYCLES  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:15] ans_ex;
    logic [0:15] store_data;
    logic        mem_rd;
    logic        mem_wr;
    logic        valid_ex;
    logic        stall_dm;
    logic [0:15] ans_dm;
    logic        valid_dm;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of words, addressed by value modulo DEPTH
    logic [15:0] model_mem [DEPTH];

    data_mem_stage #(
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ans_ex    (ans_ex),
        .store_data(store_data),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .valid_ex  (valid_ex),
        .stall_dm  (stall_dm),
        .ans_dm    (ans_dm),
        .valid_dm  (valid_dm)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    endfunction

    // Expected result of one op, updating the model memory for stores
    function automatic logic [15:0] model_op(input logic rd, input logic wr,
                                             input logic [15:0] a, input logic [15:0] d);
        int idx;
        idx = int'(a % 16'(DEPTH));
        if (wr) begin
            model_mem[idx] = d;
            return a;
        end else if (rd) begin
            return model_mem[idx];
        end
        return a;
    endfunction

    function automatic int exp_lat(input logic rd, input logic wr);
        return (rd || wr) ? WAIT_CYCLES + 1 : 1;
    endfunction

    function automatic int exp_stalls(input logic rd, input logic wr);
        return (rd || wr) ? WAIT_CYCLES : 0;
    endfunction

    // Driver: presents one op at posedge+1 and returns when valid_dm is seen.
    // With scramble set, inputs are randomised every cycle after acceptance.
    task automatic drive_op(input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] d,
                            input bit scramble,
                            output logic [15:0] res, output int lat, output int stalls);
        bit done;
        done       = 1'b0;
        ans_ex     = a;
        store_data = d;
        mem_rd     = rd;
        mem_wr     = wr;
        valid_ex   = 1'b1;
        lat        = 0;
        stalls     = 0;
        res        = 16'h0000;
        while (!done && lat < MAX_CYCLES) begin
            @(posedge clk);
            #1;
            lat++;
            if (stall_dm) stalls++;
            if (valid_dm) begin
                done     = 1'b1;
                res      = ans_dm;
                valid_ex = 1'b0;
            end else if (scramble) begin
                ans_ex     = 16'($urandom);
                store_data = 16'($urandom);
                mem_rd     = 1'($urandom);
                mem_wr     = 1'($urandom);
                valid_ex   = 1'b1;
            end else begin
                valid_ex = 1'b0;
            end
        end
        valid_ex = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: no valid_dm within %0d cycles (a=%h)", MAX_CYCLES, a);
        end
    endtask

    task automatic test_reset();
        logic [15:0] r;
        int lat, st;
        checks++;
        if (ans_dm !== 16'h0000) begin errors++; $display("FAIL rst_ans_dm: got %h want 0000", ans_dm); end
        checks++;
        if (valid_dm !== 1'b0) begin errors++; $display("FAIL rst_valid_dm: got %b want 0", valid_dm); end
        checks++;
        if (stall_dm !== 1'b0) begin errors++; $display("FAIL rst_stall_dm: got %b want 0", stall_dm); end

        // Make outputs non-zero, then reset between clock edges
        drive_op(1'b0, 1'b0, 16'h5A5A, 16'h0000, 1'b0, r, lat, st);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ans_dm !== 16'h0000) begin errors++; $display("FAIL async_rst_ans_dm: got %h want 0000", ans_dm); end
        checks++;
        if (valid_dm !== 1'b0) begin errors++; $display("FAIL async_rst_valid_dm: got %b want 0", valid_dm); end
        checks++;
        if (stall_dm !== 1'b0) begin errors++; $display("FAIL async_rst_stall_dm: got %b want 0", stall_dm); end
        model_clear();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        drive_op(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'h0000) begin errors++; $display("FAIL rst_load_addr3: got %h want 0000", r); end
    endtask

    task automatic test_pass_through();
        logic [15:0] r;
        int lat, st;
        drive_op(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'h1234) begin errors++; $display("FAIL pass_data: got %h want 1234", r); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL pass_latency: got %0d want 1", lat); end
        checks++;
        if (st !== 0) begin errors++; $display("FAIL pass_stall: got %0d stalled cycles want 0", st); end
        @(posedge clk); #1;
        checks++;
        if (valid_dm !== 1'b0) begin errors++; $display("FAIL pass_pulse_width: valid_dm got %b want 0", valid_dm); end
    endtask

    task automatic test_store_load();
        logic [15:0] r, e;
        int lat, st;
        e = model_op(1'b0, 1'b1, 16'h0005, 16'hBEEF);
        drive_op(1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, r, lat, st);
        checks++;
        if (r !== e) begin errors++; $display("FAIL store_ans: got %h want %h", r, e); end
        checks++;
        if (lat !== exp_lat(1'b0, 1'b1)) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, exp_lat(1'b0, 1'b1)); end
        checks++;
        if (st !== exp_stalls(1'b0, 1'b1)) begin errors++; $display("FAIL store_stall: got %0d want %0d", st, exp_stalls(1'b0, 1'b1)); end
        @(posedge clk); #1;
        e = model_op(1'b1, 1'b0, 16'h0005, 16'h0000);
        drive_op(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'hBEEF || r !== e) begin errors++; $display("FAIL load_after_store: got %h want %h", r, e); end
        checks++;
        if (lat !== exp_lat(1'b1, 1'b0)) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, exp_lat(1'b1, 1'b0)); end
    endtask

    task automatic test_wrap_priority();
        logic [15:0] r, e;
        int lat, st;
        e = model_op(1'b1, 1'b1, 16'hFFF5, 16'hAAAA);
        drive_op(1'b1, 1'b1, 16'hFFF5, 16'hAAAA, 1'b0, r, lat, st);
        checks++;
        if (r !== e) begin errors++; $display("FAIL prio_store_ans: got %h want %h", r, e); end
        e = model_op(1'b1, 1'b0, 16'h0005, 16'h0000);
        drive_op(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'hAAAA || r !== e) begin errors++; $display("FAIL wrap_load: got %h want %h", r, e); end
    endtask

    task automatic test_stall_honoured();
        logic [15:0] r, e;
        int lat, st, pulses;
        e = model_op(1'b0, 1'b1, 16'h0009, 16'h7E57);
        drive_op(1'b0, 1'b1, 16'h0009, 16'h7E57, 1'b1, r, lat, st);
        checks++;
        if (r !== e) begin errors++; $display("FAIL stall_latched_ans: got %h want %h", r, e); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (valid_dm) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL stall_extra_pulse: got %0d pulses want 0", pulses); end
        for (int i = 0; i < DEPTH; i++) begin
            e = model_op(1'b1, 1'b0, 16'(i), 16'h0000);
            drive_op(1'b1, 1'b0, 16'(i), 16'h0000, 1'b0, r, lat, st);
            checks++;
            if (r !== e) begin errors++; $display("FAIL stall_mem_word%0d: got %h want %h", i, r, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r, e;
        int lat, st;
        e = model_op(1'b0, 1'b1, 16'h000C, 16'hC0DE);
        drive_op(1'b0, 1'b1, 16'h000C, 16'hC0DE, 1'b0, r, lat, st);
        checks++;
        if (r !== e) begin errors++; $display("FAIL b2b_store: got %h want %h", r, e); end
        // Issue the load in the very first IDLE cycle after completion
        e = model_op(1'b1, 1'b0, 16'h000C, 16'h0000);
        drive_op(1'b1, 1'b0, 16'h000C, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== e) begin errors++; $display("FAIL b2b_load: got %h want %h", r, e); end
        checks++;
        if (lat !== exp_lat(1'b1, 1'b0)) begin errors++; $display("FAIL b2b_separate_pulse: latency got %0d want %0d", lat, exp_lat(1'b1, 1'b0)); end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] r;
        int lat, st;
        ans_ex     = 16'h0002;
        store_data = 16'h1111;
        mem_rd     = 1'b0;
        mem_wr     = 1'b1;
        valid_ex   = 1'b1;
        @(posedge clk); #1;
        valid_ex = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ans_dm !== 16'h0000) begin errors++; $display("FAIL midop_rst_ans_dm: got %h want 0000", ans_dm); end
        checks++;
        if (valid_dm !== 1'b0) begin errors++; $display("FAIL midop_rst_valid_dm: got %b want 0", valid_dm); end
        checks++;
        if (stall_dm !== 1'b0) begin errors++; $display("FAIL midop_rst_stall_dm: got %b want 0", stall_dm); end
        model_clear();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'h0000) begin errors++; $display("FAIL midop_load_addr2: got %h want 0000", r); end
        drive_op(1'b1, 1'b0, 16'h000C, 16'h0000, 1'b0, r, lat, st);
        checks++;
        if (r !== 16'h0000) begin errors++; $display("FAIL midop_mem_cleared: got %h want 0000", r); end
    endtask

    task automatic test_random();
        logic [15:0] r, e, a, d;
        logic rd, wr;
        int lat, st, gap;
        for (int n = 0; n < 60; n++) begin
            rd  = 1'($urandom);
            wr  = 1'($urandom_range(0, 2) == 0);
            a   = 16'($urandom);
            d   = 16'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                // Idle cycles with unknown rd/wr must have no effect
                mem_rd = 1'bx;
                mem_wr = 1'bx;
                @(posedge clk); #1;
            end
            e = model_op(rd, wr, a, d);
            drive_op(rd, wr, a, d, 1'b0, r, lat, st);
            checks++;
            if (r !== e) begin errors++; $display("FAIL rand%0d_data: rd=%b wr=%b a=%h got %h want %h", n, rd, wr, a, r, e); end
            checks++;
            if (lat !== exp_lat(rd, wr)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, exp_lat(rd, wr)); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        ans_ex     = 16'h0000;
        store_data = 16'h0000;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        valid_ex   = 1'b0;
        model_clear();
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_pass_through();
        test_store_load();
        test_wrap_priority();
        test_stall_honoured();
        test_back_to_back();
        test_reset_mid_op();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
